// File: rtl/ascon_sequencer_if.sv
//------------------------------------------------------------------------------
// Module : ascon_sequencer_if
// Brief  : Host handshake and datapath-control bundle of the ASCON-128 sequencer.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface ascon_sequencer_if;
    logic       start_i;
    logic       data_valid_i;
    logic       data_ready_o;
    logic [3:0] round_o;
    logic       en_reg_state_o;
    logic       init_sel_o;
    logic       en_xor_data_o;
    logic       en_xor_key_begin_o;
    logic       en_xor_key_end_o;
    logic       en_xor_lsb_o;
    logic       en_cipher_o;
    logic       en_tag_o;
    logic       end_o;

    modport master (
        output start_i, data_valid_i,
        input  data_ready_o, round_o, en_reg_state_o, init_sel_o, en_xor_data_o,
        input  en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_cipher_o,
        input  en_tag_o, end_o
    );

    modport slave (
        input  start_i, data_valid_i,
        output data_ready_o, round_o, en_reg_state_o, init_sel_o, en_xor_data_o,
        output en_xor_key_begin_o, en_xor_key_end_o, en_xor_lsb_o, en_cipher_o,
        output en_tag_o, end_o
    );
endinterface

`default_nettype wire

// File: rtl/ascon_sequencer.sv
//------------------------------------------------------------------------------
// Module : ascon_sequencer
// Brief  : Round/phase sequencer for the ASCON-128 encryption datapath.
//          Macro ASCON_AD_PHASE_EN enables the associated-data phase.
// Rev    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module ascon_sequencer #(
    parameter int NB_AD_BLOCKS = 1,
    parameter int NB_PT_BLOCKS = 4
) (
    input  wire logic        clock_i,
    input  wire logic        reset_i,
    ascon_sequencer_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_INIT    = 3'd1,
        S_WAIT_AD = 3'd2,
        S_AD      = 3'd3,
        S_WAIT_PT = 3'd4,
        S_PT      = 3'd5,
        S_FINAL   = 3'd6,
        S_DONE    = 3'd7
    } state_t;

    localparam logic [3:0] c_round_p12 = 4'd0;
    localparam logic [3:0] c_round_p6  = 4'd6;
    localparam logic [3:0] c_round_end = 4'd11;
    localparam logic [7:0] c_pt_last   = 8'(NB_PT_BLOCKS - 1);
`ifdef ASCON_AD_PHASE_EN
    localparam logic [7:0] c_ad_last   = 8'(NB_AD_BLOCKS);
`endif

    if (NB_AD_BLOCKS < 1 || NB_PT_BLOCKS < 1) begin : g_param_check
        $error("ascon_sequencer: block counts must be at least 1");
    end

    state_t     r_state, w_state_nxt;
    logic [3:0] r_round, w_round_nxt;
    logic [7:0] r_blk,   w_blk_nxt;

    logic r_ready, r_init_sel, r_en_reg, r_xor_data, r_key_begin;
    logic r_key_end, r_lsb, r_cipher, r_tag, r_end;
    logic w_ready, w_init_sel, w_en_reg, w_xor_data, w_key_begin;
    logic w_key_end, w_lsb, w_cipher, w_tag, w_end;
    logic w_r0, w_r6, w_r11;

    // Next state, round index and block count
    always_comb begin
        w_state_nxt = r_state;
        w_round_nxt = r_round;
        w_blk_nxt   = r_blk;
        case (r_state)
            S_IDLE: begin
                if (bus.start_i) begin
                    w_state_nxt = S_INIT;
                    w_round_nxt = c_round_p12;
                    w_blk_nxt   = 8'd0;
                end
            end
            S_INIT: begin
                if (r_round == c_round_end) begin
`ifdef ASCON_AD_PHASE_EN
                    w_state_nxt = S_WAIT_AD;
`else
                    w_state_nxt = S_WAIT_PT;
`endif
                    w_round_nxt = c_round_p6;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
`ifdef ASCON_AD_PHASE_EN
            S_WAIT_AD: begin
                if (bus.data_valid_i) begin
                    w_state_nxt = S_AD;
                    w_blk_nxt   = r_blk + 8'd1;
                end
            end
            S_AD: begin
                if (r_round == c_round_end) begin
                    w_round_nxt = c_round_p6;
                    if (r_blk == c_ad_last) begin
                        w_state_nxt = S_WAIT_PT;
                        w_blk_nxt   = 8'd0;
                    end else begin
                        w_state_nxt = S_WAIT_AD;
                    end
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
`endif
            S_WAIT_PT: begin
                if (bus.data_valid_i) begin
                    w_blk_nxt = r_blk + 8'd1;
                    if (r_blk == c_pt_last) begin
                        w_state_nxt = S_FINAL;
                        w_round_nxt = c_round_p12;
                    end else begin
                        w_state_nxt = S_PT;
                    end
                end
            end
            S_PT: begin
                if (r_round == c_round_end) begin
                    w_state_nxt = S_WAIT_PT;
                    w_round_nxt = c_round_p6;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            S_FINAL: begin
                if (r_round == c_round_end) begin
                    w_state_nxt = S_DONE;
                    w_round_nxt = c_round_p12;
                end else begin
                    w_round_nxt = r_round + 4'd1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_round_nxt = c_round_p12;
            end
        endcase
    end

    // Outputs are decoded from the next state so they are registered yet
    // aligned with the state/round they describe.
    always_comb begin
        w_r0        = (w_round_nxt == c_round_p12);
        w_r6        = (w_round_nxt == c_round_p6);
        w_r11       = (w_round_nxt == c_round_end);
        w_ready     = (w_state_nxt == S_WAIT_PT);
        w_en_reg    = (w_state_nxt == S_INIT) || (w_state_nxt == S_PT) ||
                      (w_state_nxt == S_FINAL);
        w_init_sel  = (w_state_nxt == S_INIT) && w_r0;
        w_cipher    = ((w_state_nxt == S_PT) && w_r6) || ((w_state_nxt == S_FINAL) && w_r0);
        w_xor_data  = w_cipher;
        w_key_begin = (w_state_nxt == S_FINAL) && w_r0;
        w_key_end   = ((w_state_nxt == S_INIT) || (w_state_nxt == S_FINAL)) && w_r11;
        w_tag       = (w_state_nxt == S_FINAL) && w_r11;
        w_end       = (w_state_nxt == S_DONE);
`ifdef ASCON_AD_PHASE_EN
        w_ready     = w_ready || (w_state_nxt == S_WAIT_AD);
        w_en_reg    = w_en_reg || (w_state_nxt == S_AD);
        w_xor_data  = w_xor_data || ((w_state_nxt == S_AD) && w_r6);
        w_lsb       = (w_state_nxt == S_AD) && w_r11 && (w_blk_nxt == c_ad_last);
`else
        // Without AD, domain separation is applied at the end of initialisation
        w_lsb       = (w_state_nxt == S_INIT) && w_r11;
`endif
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            r_state     <= S_IDLE;
            r_round     <= 4'd0;
            r_blk       <= 8'd0;
            r_ready     <= 1'b0;
            r_init_sel  <= 1'b0;
            r_en_reg    <= 1'b0;
            r_xor_data  <= 1'b0;
            r_key_begin <= 1'b0;
            r_key_end   <= 1'b0;
            r_lsb       <= 1'b0;
            r_cipher    <= 1'b0;
            r_tag       <= 1'b0;
            r_end       <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_round     <= w_round_nxt;
            r_blk       <= w_blk_nxt;
            r_ready     <= w_ready;
            r_init_sel  <= w_init_sel;
            r_en_reg    <= w_en_reg;
            r_xor_data  <= w_xor_data;
            r_key_begin <= w_key_begin;
            r_key_end   <= w_key_end;
            r_lsb       <= w_lsb;
            r_cipher    <= w_cipher;
            r_tag       <= w_tag;
            r_end       <= w_end;
        end
    end

    assign bus.data_ready_o       = r_ready;
    assign bus.round_o            = r_round;
    assign bus.en_reg_state_o     = r_en_reg;
    assign bus.init_sel_o         = r_init_sel;
    assign bus.en_xor_data_o      = r_xor_data;
    assign bus.en_xor_key_begin_o = r_key_begin;
    assign bus.en_xor_key_end_o   = r_key_end;
    assign bus.en_xor_lsb_o       = r_lsb;
    assign bus.en_cipher_o        = r_cipher;
    assign bus.en_tag_o           = r_tag;
    assign bus.end_o              = r_end;

endmodule

`default_nettype wire

// File: doc/ascon_sequencer.md
# ascon_sequencer

Cycle-level controller for the ASCON-128 encryption datapath. It sequences the 320-bit state register (`registre_selection`) and the one-round-per-cycle permutation through the phases initialisation, associated data, plaintext and finalisation. It drives the state-register enable, the round index and the XOR/capture enables. It also paces 64-bit data blocks from the host through a ready/valid handshake.

## Interface
Parameters:
- `NB_AD_BLOCKS`, default 1: number of 64-bit associated-data blocks (≥1).
- `NB_PT_BLOCKS`, default 4: number of 64-bit plaintext blocks (≥1).

Ports:
- `clock_i`, in, 1: single clock; all logic on rising edge.
- `reset_i`, in, 1: synchronous, active-high reset.
- `start_i`, in, 1: begin one encryption; sampled only in IDLE.
- `data_valid_i`, in, 1: host presents the next AD/PT block.
- `data_ready_o`, out, 1: sequencer waiting for a block.
- `round_o`, out, 4: round index (0..11) fed to the permutation constant-add.
- `en_reg_state_o`, out, 1: state register load enable.
- `init_sel_o`, out, 1: permutation input = IV‖K‖N instead of register.
- `en_xor_data_o`, out, 1: XOR block into rate before the round.
- `en_xor_key_begin_o`, out, 1: XOR 0‖K‖0* before the round.
- `en_xor_key_end_o`, out, 1: XOR 0*‖K after the round.
- `en_xor_lsb_o`, out, 1: XOR domain-separation bit (LSB) after the round.
- `en_cipher_o`, out, 1: capture ciphertext block.
- `en_tag_o`, out, 1: capture 128-bit tag.
- `end_o`, out, 1: one-cycle done pulse.

## Operation
- States: IDLE, INIT, WAIT_AD, AD, WAIT_PT, PT, FINAL, DONE.
- Each permutation round takes one cycle. `en_reg_state_o`=1 in every INIT/AD/PT/FINAL cycle and 0 elsewhere.
- Round counter width is 4. In IDLE and WAIT states it holds the phase start value.
  - p12 phases (INIT, FINAL) count 0..11.
  - p6 phases (AD, PT) count 6..11.
  - A phase exits on the cycle where `round_o`=11.
- Block counter width is 8. It is cleared at start and at the AD→PT transition, and increments at each block consumption.
- IDLE: if `start_i`=1, go to INIT with round 0.
- INIT: `init_sel_o`=1 on round 0 only. On round 11, `en_xor_key_end_o`=1, then go to WAIT_AD.
- WAIT_AD: `data_ready_o`=1 and round held at 6. If `data_valid_i`=1, go to AD.
- AD: `en_xor_data_o`=1 on round 6. On round 11, go to WAIT_AD; for the last AD block, also assert `en_xor_lsb_o` and go to WAIT_PT instead.
- WAIT_PT: `data_ready_o`=1. If `data_valid_i`=1, go to PT for a non-last block or to FINAL (round 0) for the last block.
- PT: `en_xor_data_o`=1 and `en_cipher_o`=1 on round 6. On round 11, go to WAIT_PT.
- FINAL: on round 0, `en_xor_data_o`, `en_cipher_o` and `en_xor_key_begin_o` are all 1. On round 11, `en_xor_key_end_o`=1 and `en_tag_o`=1, then go to DONE.
- DONE: `end_o`=1 for one cycle, then go to IDLE.
- Exactly one block is consumed per WAIT-state exit. If `data_valid_i` is held high, one block is consumed per phase, never two.
- `start_i` is ignored outside IDLE. `data_valid_i` is ignored outside WAIT states.
- `NB_PT_BLOCKS`=1: the first WAIT_PT goes directly to FINAL.

## Timing
- All outputs are Moore-decoded from state and round; there is no combinational path from inputs to outputs.
- Reset values: all outputs 0, state IDLE, both counters 0.
- `reset_i` takes priority in every state: the block is in IDLE on the next cycle and any encryption in progress is aborted with no `end_o`.
- Reference schedule (defaults, `data_valid_i` tied to 1, `start_i` sampled at edge E0; cycle n follows E0):

| Cycles | State |
|---|---|
| 1–12 | INIT |
| 13 | WAIT_AD |
| 14–19 | AD |
| 20 | WAIT_PT |
| 21–26 | PT |
| 27 | WAIT_PT |
| 28–33 | PT |
| 34 | WAIT_PT |
| 35–40 | PT |
| 41 | WAIT_PT |
| 42–53 | FINAL |
| 54 | DONE |

- General latency: 12 + 7·`NB_AD_BLOCKS` + 7·(`NB_PT_BLOCKS`−1) + 1 + 12 + 1 cycles, plus any host stall cycles spent in WAIT states.

## Configuration
- Macro: `ASCON_AD_PHASE_EN`.
- Defined: the full flow above, including the AD phase.
- Undefined:
  - WAIT_AD and AD are removed and `NB_AD_BLOCKS` is unused.
  - INIT goes directly to WAIT_PT.
  - On INIT round 11, `en_xor_key_end_o` and `en_xor_lsb_o` are both 1.
  - Default-parameter latency is 47 cycles (`end_o` in cycle 47).

## Test plan
- Reset: `reset_i`=1 for 2 cycles with `start_i`=1 → all outputs 0, `round_o`=0, no state change.
- Nominal run: defaults, `data_valid_i`=1, `start_i` pulse → `init_sel_o` in cycle 1; `en_xor_lsb_o` in cycle 19; `en_cipher_o` in cycles 21, 28, 35, 42; `en_tag_o` in cycle 53; `end_o` in cycle 54 only; `en_reg_state_o` high for exactly 54−6=48 cycles.
- Host stall: hold `data_valid_i`=0 for 5 cycles in the first WAIT_PT → `data_ready_o` high 6 cycles, `round_o`=6 and `en_reg_state_o`=0 throughout; `end_o` moves to cycle 59.
- Abort: assert `reset_i` in AD cycle 16 → IDLE next cycle, outputs 0; a new `start_i` then completes normally with `end_o` 54 cycles later.
- Ignored inputs: pulse `start_i` during PT and `data_valid_i` during INIT → schedule is identical to the nominal run.
- Compile-out: build without `ASCON_AD_PHASE_EN` and use `NB_PT_BLOCKS`=1 → `en_xor_key_end_o` and `en_xor_lsb_o` together in cycle 12; FINAL in cycles 14–25; `end_o` in cycle 26.
